// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
// Build option: SRAM_ARB_INIT_CLEAR_EN zero-fills the SRAM after every reset.
package sram_arb_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } arb_state_e;

    // Cycles from a read handshake to its rsp_valid pulse.
    localparam int RD_LAT     = 2;
    localparam int MAX_REQ    = 4;
    localparam int TAG_ID_BIT = $clog2(MAX_REQ);

    // One slot of the read-response pipe.
    typedef struct packed {
        logic                  valid;
        logic [TAG_ID_BIT-1:0] id;
    } rsp_tag_t;

    // (a + b) mod n for operands already below n.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b >= n) ? (a + b - n) : (a + b);
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Round-robin pick among NUM_REQ requesters: the lowest index at or above
// ptr that is valid wins, otherwise the search wraps to index 0.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_BIT  = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_BIT-1:0]  ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_BIT-1:0]  id,
    output logic               any
);

    // Two passes: indices >= ptr first, then the wrapped indices below ptr.
    always_comb begin
        // NOTE: every output gets a default before the loops, so no path can infer a latch.
        grant = '0;
        id    = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && valid[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                id       = ID_BIT'(i);
                any      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && valid[i] && (i < int'(ptr))) begin
                grant[i] = 1'b1;
                id       = ID_BIT'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_sp_arbiter.sv
// Shares one single-port SRAM among NUM_REQ valid/ready requesters with
// round-robin grant; read data is routed back by requester id two cycles
// after the handshake.
// Build option: SRAM_ARB_INIT_CLEAR_EN adds an INIT phase that zero-fills
// every word after reset before any request is accepted.
module sram_sp_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_BIT = 32,
    parameter int DEPTH    = 512,
    parameter int ADDR_BIT = $clog2(DEPTH),
    parameter int NUM_REQ  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_BIT-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_BIT-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_BIT-1:0]          rsp_rdata,
    output logic                         init_done,
    output logic [ADDR_BIT-1:0]          mem_addr,
    output logic                         mem_wen,
    output logic                         mem_ren,
    output logic [DATA_BIT-1:0]          mem_wdata,
    output logic [DATA_BIT-1:0]          mem_bwe,
    input  logic [DATA_BIT-1:0]          mem_rdata
);

    localparam int ID_BIT = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef SRAM_ARB_INIT_CLEAR_EN
    localparam arb_state_e RST_STATE = ST_INIT;
`else
    localparam arb_state_e RST_STATE = ST_RUN;
`endif

    arb_state_e             state_q, state_d;
    logic                   init_done_q;
    logic [ID_BIT-1:0]      ptr_q;
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [ID_BIT-1:0]      arb_id;
    logic                   arb_any;
    logic                   run, hs, init_wr, init_last;
    logic [ADDR_BIT-1:0]    init_addr;
    logic                   sel_we;
    logic [ADDR_BIT-1:0]    sel_addr;
    logic [DATA_BIT-1:0]    sel_wdata;
    rsp_tag_t [RD_LAT-1:0]  pipe_q;
    rsp_tag_t               tag_d, tag_out;
    logic [DATA_BIT-1:0]    rdata_hold_q;

`ifdef SRAM_ARB_INIT_CLEAR_EN
    logic [ADDR_BIT-1:0] init_cnt_q;

    // Zero-fill address counter: walks every word once while in INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + ADDR_BIT'(1);
        end
    end

    assign init_addr = init_cnt_q;
    assign init_last = (init_cnt_q == ADDR_BIT'(DEPTH - 1));
`else
    assign init_addr = '0;
    assign init_last = 1'b1;
`endif

    sram_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_BIT  (ID_BIT)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (arb_gnt),
        .id    (arb_id),
        .any   (arb_any)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant gating and handshake detection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_last) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = RST_STATE;
        endcase
        run       = init_done_q && (state_q == ST_RUN);
        req_ready = run ? arb_gnt : '0;
        hs        = run && arb_any;
        init_wr   = (state_q == ST_INIT);
    end

    // init_done follows the state with one register so it stays low in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= (state_d == ST_RUN);
        end
    end

    assign init_done = init_done_q;

    // Round-robin pointer moves past the winner only on a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (hs) begin
            ptr_q <= ID_BIT'(wrap_add(int'(arb_id), 1, NUM_REQ));
        end
    end

    // Select the granted requester's command fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_BIT +: ADDR_BIT];
                sel_wdata = req_wdata[i*DATA_BIT +: DATA_BIT];
            end
        end
    end

    // Registered SRAM command: zero-fill writes in INIT, otherwise the granted op.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
        end else begin
            mem_wen <= 1'b0;
            mem_ren <= 1'b0;
            if (init_wr) begin
                mem_wen   <= 1'b1;
                mem_addr  <= init_addr;
                mem_wdata <= '0;
            end else if (hs) begin
                mem_wen   <= sel_we;
                mem_ren   <= !sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    // Tag entering the response pipe: only reads produce a response.
    always_comb begin
        tag_d.valid = hs && !sel_we;
        tag_d.id    = TAG_ID_BIT'(arb_id);
    end

    // Response pipe: one stage per cycle of SRAM read latency.
    always_ff @(posedge clk) begin
        // NOTE: the tag pipe is reset so in-flight reads die with rst; the SRAM array is never reset here.
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= tag_d;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    assign tag_out   = pipe_q[RD_LAT-1];
    assign rsp_valid = tag_out.valid ? (NUM_REQ'(1) << tag_out.id) : '0;

    // Keep the last delivered word so rsp_rdata is stable between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_hold_q <= '0;
        end else if (tag_out.valid) begin
            rdata_hold_q <= mem_rdata;
        end
    end

    assign rsp_rdata = tag_out.valid ? mem_rdata : rdata_hold_q;
    assign mem_bwe   = '1;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Self-checking bench for sram_sp_arbiter: a behavioural SRAM plus a
// reference model (array memory, queue of expected responses, modulo
// round-robin pick) checked every cycle on the falling edge.
module tb_sram_sp_arbiter;

    localparam int DATA_BIT = 32;
    localparam int DEPTH    = 64;
    localparam int ADDR_BIT = 6;
    localparam int NUM_REQ  = 2;

`ifdef SRAM_ARB_INIT_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif
    // Cycle index (counted from the first cycle after reset release) where init_done is first high.
    localparam int RUN_AFTER = CLEAR_EN ? DEPTH : 1;

    logic                         clk;
    logic                         rst;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           req_we;
    logic [NUM_REQ*ADDR_BIT-1:0]  req_addr;
    logic [NUM_REQ*DATA_BIT-1:0]  req_wdata;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [DATA_BIT-1:0]          rsp_rdata;
    logic                         init_done;
    logic [ADDR_BIT-1:0]          mem_addr;
    logic                         mem_wen;
    logic                         mem_ren;
    logic [DATA_BIT-1:0]          mem_wdata;
    logic [DATA_BIT-1:0]          mem_bwe;
    logic [DATA_BIT-1:0]          mem_rdata;

    sram_sp_arbiter #(
        .DATA_BIT (DATA_BIT),
        .DEPTH    (DEPTH),
        .ADDR_BIT (ADDR_BIT),
        .NUM_REQ  (NUM_REQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_wdata (mem_wdata),
        .mem_bwe   (mem_bwe),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM: read data appears the cycle after ren.
    logic [DATA_BIT-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (mem_wen) sram[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= sram[mem_addr];
    end

    // Reference model state.
    typedef struct {
        int                  due;
        int                  id;
        logic [DATA_BIT-1:0] data;
    } rsp_t;

    logic [DATA_BIT-1:0] ref_mem [DEPTH];
    rsp_t                rsp_q[$];
    int                  cyc, since, ptr_m, last_win;
    logic [DATA_BIT-1:0] last_rdata;
    logic                exp_wen, exp_ren;
    logic [ADDR_BIT-1:0] exp_addr;
    logic [DATA_BIT-1:0] exp_wdata;
    int                  checks, errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input int addr,
                           input logic [DATA_BIT-1:0] data);
        req_valid[i] = v;
        req_we[i]    = we;
        req_addr[i*ADDR_BIT +: ADDR_BIT]  = ADDR_BIT'(addr);
        req_wdata[i*DATA_BIT +: DATA_BIT] = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_q.delete();
        ptr_m      = 0;
        since      = 0;
        last_rdata = '0;
        exp_wen    = 1'b0;
        exp_ren    = 1'b0;
        exp_addr   = '0;
        exp_wdata  = '0;
        if (CLEAR_EN) begin
            foreach (ref_mem[i]) ref_mem[i] = '0;
        end
    endtask

    // One clock: compare all outputs at the falling edge, then advance the model.
    task automatic tick();
        int                  win;
        logic [NUM_REQ-1:0]  exp_rdy;
        logic [NUM_REQ-1:0]  exp_v;
        logic [DATA_BIT-1:0] exp_d;
        logic [ADDR_BIT-1:0] a;
        logic [DATA_BIT-1:0] d;
        @(negedge clk);
        win = -1;
        if (since >= RUN_AFTER) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (ptr_m + k) % NUM_REQ;
                if (win < 0 && req_valid[i]) win = i;
            end
        end
        exp_rdy = (win >= 0) ? (NUM_REQ'(1) << win) : '0;
        check("init_done", 64'(init_done), 64'(since >= RUN_AFTER));
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("mem_wen", 64'(mem_wen), 64'(exp_wen));
        check("mem_ren", 64'(mem_ren), 64'(exp_ren));
        check("mem_addr", 64'(mem_addr), 64'(exp_addr));
        if (exp_wen) check("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));

        exp_v = '0;
        exp_d = last_rdata;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            exp_v      = NUM_REQ'(1) << rsp_q[0].id;
            exp_d      = rsp_q[0].data;
            last_rdata = exp_d;
            void'(rsp_q.pop_front());
        end
        check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_d));

        if (CLEAR_EN && since < DEPTH) begin
            exp_wen   = 1'b1;
            exp_ren   = 1'b0;
            exp_addr  = ADDR_BIT'(since);
            exp_wdata = '0;
        end else if (win >= 0) begin
            a         = req_addr[win*ADDR_BIT +: ADDR_BIT];
            d         = req_wdata[win*DATA_BIT +: DATA_BIT];
            exp_wen   = req_we[win];
            exp_ren   = !req_we[win];
            exp_addr  = a;
            exp_wdata = d;
            if (req_we[win]) ref_mem[a] = d;
            else rsp_q.push_back('{due: cyc + 2, id: win, data: ref_mem[a]});
            ptr_m = (win + 1) % NUM_REQ;
        end else begin
            exp_wen = 1'b0;
            exp_ren = 1'b0;
        end
        last_win = win;
        @(posedge clk);
        #1;
        cyc++;
        since++;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        last_win  = -1;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = 32'hA5A5_0000 + DATA_BIT'(i * 17);
            ref_mem[i] = 32'hA5A5_0000 + DATA_BIT'(i * 17);
        end

        // Reset state; requester 0 already holds a write that must wait for init_done.
        do_reset();
        check("mem_bwe", 64'(mem_bwe), 64'({DATA_BIT{1'b1}}));
        set_req(0, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
        while (since < RUN_AFTER) tick();

        // Write 0xDEADBEEF to addr 3, read it back the very next cycle.
        tick();
        set_req(0, 1'b1, 1'b0, 3, '0);
        tick();
        set_req(0, 1'b0, 1'b0, 0, '0);
        repeat (3) tick();

        // Read of an untouched word (zero when the clear phase is built in).
        set_req(0, 1'b1, 1'b0, 5, '0);
        tick();
        set_req(0, 1'b0, 1'b0, 0, '0);
        repeat (3) tick();

        // Requester 1 alone: four back-to-back reads.
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, 1'b0, 10 + k, '0);
            tick();
        end
        set_req(1, 1'b0, 1'b0, 0, '0);
        repeat (3) tick();

        // Both requesters reading continuously: grants alternate.
        set_req(0, 1'b1, 1'b0, 1, '0);
        set_req(1, 1'b1, 1'b0, 2, '0);
        repeat (6) tick();
        set_req(0, 1'b0, 1'b0, 0, '0);
        set_req(1, 1'b0, 1'b0, 0, '0);
        repeat (3) tick();

        // Random traffic; a requester holds its request until it is granted.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom());
                end
            end
            tick();
            if (last_win >= 0) req_valid[last_win] = 1'b0;
        end
        req_valid = '0;
        repeat (3) tick();

        // Read handshake, then reset the next cycle: the response must never appear.
        set_req(0, 1'b1, 1'b0, 7, '0);
        tick();
        set_req(1, 1'b1, 1'b0, 8, '0);
        do_reset();
        while (since < RUN_AFTER) tick();
        repeat (4) tick();
        req_valid = '0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
